// File: rtl/wave_voice_scheduler.sv
// Time-division scheduler sharing one wave LUT among NUM_VOICES voices, one slot per clock.
// Optional voice-0 hard sync of other voices is enabled by defining WAVE_SCHED_HARD_SYNC_EN.
module wave_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 12,
    parameter int VID_W      = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    cfg_we_in,
    input  logic [VID_W-1:0]        cfg_voice_in,
    input  logic [DIV_W-1:0]        cfg_period_in,
    input  logic [2:0]              cfg_type_in,
    input  logic                    cfg_enable_in,
`ifdef WAVE_SCHED_HARD_SYNC_EN
    input  logic [NUM_VOICES-1:0]   sync_mask_in,
`endif
    output logic [4:0]              lut_addr_out,
    output logic [2:0]              wave_type_out,
    input  logic [15:0]             lut_data_in,
    output logic [VID_W-1:0]        slot_out,
    output logic [4*NUM_VOICES-1:0] sample_out,
    output logic [NUM_VOICES-1:0]   sample_valid_out
);

    logic [VID_W-1:0]      slot_q, slot_d;
    logic [DIV_W-1:0]      period_q [NUM_VOICES];
    logic [DIV_W-1:0]      period_d [NUM_VOICES];
    logic [DIV_W-1:0]      div_q    [NUM_VOICES];
    logic [DIV_W-1:0]      div_d    [NUM_VOICES];
    logic [2:0]            type_q   [NUM_VOICES];
    logic [2:0]            type_d   [NUM_VOICES];
    logic [4:0]            phase_q  [NUM_VOICES];
    logic [4:0]            phase_d  [NUM_VOICES];
    logic [3:0]            sample_q [NUM_VOICES];
    logic [3:0]            sample_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [NUM_VOICES-1:0] valid_q, valid_d;
    logic [3:0]            captured;
    logic                  unused_bits;

`ifdef WAVE_SCHED_HARD_SYNC_EN
    logic v0_wrap;
    assign unused_bits = ^{lut_data_in[11:1], sync_mask_in[0]};
`else
    assign unused_bits = ^lut_data_in[11:1];
`endif

    // Square-type waves only carry their level in bit 0 of the LUT word.
    assign captured = wave_type_out[2] ? lut_data_in[15:12] : {4{lut_data_in[0]}};

    always_comb begin
        lut_addr_out  = '0;
        wave_type_out = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (slot_q == VID_W'(k)) begin
                lut_addr_out  = phase_q[k];
                wave_type_out = type_q[k];
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path leaves it unassigned (no latch).
        slot_d   = (slot_q == VID_W'(NUM_VOICES - 1)) ? '0 : slot_q + VID_W'(1);
        period_d = period_q;
        div_d    = div_q;
        type_d   = type_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        en_d     = en_q;
        valid_d  = '0;

`ifdef WAVE_SCHED_HARD_SYNC_EN
        // A config write to voice 0 on its visit drops the step, so no wrap happens then.
        v0_wrap = (slot_q == '0) && en_q[0] && (div_q[0] == '0) && (phase_q[0] == 5'd31)
                  && !(cfg_we_in && (cfg_voice_in == '0));
`endif

        for (int k = 0; k < NUM_VOICES; k++) begin
            if (slot_q == VID_W'(k)) begin
                if (en_q[k]) begin
                    sample_d[k] = captured;
                    valid_d[k]  = 1'b1;
                    if (div_q[k] == '0) begin
                        div_d[k]   = period_q[k];
                        phase_d[k] = phase_q[k] + 5'd1;
                    end else begin
                        div_d[k] = div_q[k] - DIV_W'(1);
                    end
                end else begin
                    sample_d[k] = '0;
                end
            end

`ifdef WAVE_SCHED_HARD_SYNC_EN
            if (k != 0 && v0_wrap && sync_mask_in[k] && en_q[k]) begin
                phase_d[k] = '0;
                div_d[k]   = period_q[k];
            end
`endif

            // The write lands last so it overrides both the visit step and any sync.
            if (cfg_we_in && (cfg_voice_in == VID_W'(k))) begin
                period_d[k] = cfg_period_in;
                type_d[k]   = cfg_type_in;
                en_d[k]     = cfg_enable_in;
                div_d[k]    = cfg_period_in;
                phase_d[k]  = (!en_q[k] && cfg_enable_in) ? '0 : phase_q[k];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            slot_q  <= '0;
            en_q    <= '0;
            valid_q <= '0;
            // NOTE: the per-voice arrays are small flop banks, not RAM, so they are reset like any register.
            for (int k = 0; k < NUM_VOICES; k++) begin
                period_q[k] <= '0;
                div_q[k]    <= '0;
                type_q[k]   <= '0;
                phase_q[k]  <= '0;
                sample_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            slot_q   <= slot_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            div_q    <= div_d;
            type_q   <= type_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        sample_out = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            sample_out[4*k +: 4] = sample_q[k];
        end
    end

    assign slot_out         = slot_q;
    assign sample_valid_out = valid_q;

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// Self-checking bench for wave_voice_scheduler: directed table, corner sequences, and random
// traffic compared against a rule-level reference model. Covers WAVE_SCHED_HARD_SYNC_EN builds too.
module tb_wave_voice_scheduler;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int VW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            drv_we;
    logic [VW-1:0]   drv_voice;
    logic [DW-1:0]   drv_period;
    logic [2:0]      drv_type;
    logic            drv_en;
`ifdef WAVE_SCHED_HARD_SYNC_EN
    logic [N-1:0]    drv_mask;
`endif
    logic [4:0]      lut_addr;
    logic [2:0]      wave_type;
    logic [15:0]     lut_data;
    logic [VW-1:0]   slot;
    logic [4*N-1:0]  sample;
    logic [N-1:0]    valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one entry per voice.
    int m_slot;
    int m_period [N];
    int m_type   [N];
    int m_en     [N];
    int m_div    [N];
    int m_phase  [N];
    int m_sample [N];
    int m_valid  [N];

    wave_voice_scheduler #(.NUM_VOICES(N), .DIV_W(DW), .VID_W(VW)) dut (
        .clk_in          (clk),
        .reset_n_in      (rst_n),
        .cfg_we_in       (drv_we),
        .cfg_voice_in    (drv_voice),
        .cfg_period_in   (drv_period),
        .cfg_type_in     (drv_type),
        .cfg_enable_in   (drv_en),
`ifdef WAVE_SCHED_HARD_SYNC_EN
        .sync_mask_in    (drv_mask),
`endif
        .lut_addr_out    (lut_addr),
        .wave_type_out   (wave_type),
        .lut_data_in     (lut_data),
        .slot_out        (slot),
        .sample_out      (sample),
        .sample_valid_out(valid)
    );

    always #5 clk = ~clk;

    // LUT stand-in: square level in bit 0 for type[2]=0, distinctive nibble in [15:12] otherwise.
    function automatic logic [15:0] lut_fn(input logic [4:0] a, input logic [2:0] t);
        if (t == 3'b100) return 16'hA000;
        if (t[2])        return {a[3:0] ^ {2'b00, t[1:0]}, 12'h5A5};
        return {t, a, 7'h00, a[4]};
    endfunction

    assign lut_data = lut_fn(lut_addr, wave_type);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot = 0;
        for (int k = 0; k < N; k++) begin
            m_period[k] = 0; m_type[k] = 0; m_en[k] = 0; m_div[k] = 0;
            m_phase[k]  = 0; m_sample[k] = 0; m_valid[k] = 0;
        end
    endtask

    // One clock edge of the scheduler, straight from the behavioural rules.
    task automatic model_step();
        int s = m_slot;
        int n_phase [N];
        int n_div   [N];
        bit wrap0 = 0;
        logic [15:0] d;
        n_phase = m_phase;
        n_div   = m_div;
        for (int k = 0; k < N; k++) m_valid[k] = 0;
        if (m_en[s] != 0) begin
            d = lut_fn(5'(m_phase[s]), 3'(m_type[s]));
            if ((m_type[s] & 4) != 0) m_sample[s] = int'(d[15:12]);
            else                      m_sample[s] = d[0] ? 15 : 0;
            m_valid[s] = 1;
            if (m_div[s] == 0) begin
                n_div[s]   = m_period[s];
                n_phase[s] = (m_phase[s] + 1) % 32;
                wrap0      = (s == 0) && (m_phase[s] == 31);
            end else begin
                n_div[s] = m_div[s] - 1;
            end
        end else begin
            m_sample[s] = 0;
        end
`ifdef WAVE_SCHED_HARD_SYNC_EN
        if (wrap0 && !(drv_we && drv_voice == 0)) begin
            for (int k = 1; k < N; k++) begin
                if (drv_mask[k] && m_en[k] != 0) begin
                    n_phase[k] = 0;
                    n_div[k]   = m_period[k];
                end
            end
        end
`endif
        if (drv_we && int'(drv_voice) < N) begin
            int v = int'(drv_voice);
            n_div[v]   = int'(drv_period);
            n_phase[v] = (m_en[v] == 0 && drv_en) ? 0 : m_phase[v];
            m_period[v] = int'(drv_period);
            m_type[v]   = int'(drv_type);
            m_en[v]     = int'(drv_en);
        end
        m_phase = n_phase;
        m_div   = n_div;
        m_slot  = (s + 1) % N;
    endtask

    task automatic compare_model();
        logic [4*N-1:0] es = '0;
        logic [N-1:0]   ev = '0;
        for (int k = 0; k < N; k++) begin
            es[4*k +: 4] = 4'(m_sample[k]);
            ev[k]        = (m_valid[k] != 0);
        end
        check("slot",   32'(slot),      32'(m_slot));
        check("addr",   32'(lut_addr),  32'(m_phase[m_slot]));
        check("type",   32'(wave_type), 32'(m_type[m_slot]));
        check("sample", 32'(sample),    32'(es));
        check("valid",  32'(valid),     32'(ev));
    endtask

    // Inputs change only at the falling edge; outputs are compared at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        drv_we = 1'b0; drv_voice = '0; drv_period = '0; drv_type = '0; drv_en = 1'b0;
    endtask

    task automatic write_cfg(input int v, input int p, input int t, input bit e);
        drv_we = 1'b1; drv_voice = VW'(v); drv_period = DW'(p); drv_type = 3'(t); drv_en = e;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          we;
        logic [VW-1:0] voice;
        logic [DW-1:0] period;
        logic [2:0]    typ;
        logic          en;
        logic [VW-1:0] exp_slot;
        logic [4:0]    exp_addr;
        logic [2:0]    exp_type;
        logic [15:0]   exp_sample;
        logic [3:0]    exp_valid;
    } vec_t;

    vec_t vec [13];

    initial begin
        int exp_ph;
        int cap_ph;
        int pre_ph;
        int visits;

        vec[0]  = '{1'b1, 3'd2, 12'd0, 3'b100, 1'b1, 3'd1, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[1]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd2, 5'd0, 3'd4, 16'h0000, 4'b0000};
        vec[2]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd3, 5'd0, 3'd0, 16'h0A00, 4'b0100};
        vec[3]  = '{1'b1, 3'd2, 12'd0, 3'b100, 1'b0, 3'd0, 5'd0, 3'd0, 16'h0A00, 4'b0000};
        vec[4]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd1, 5'd0, 3'd0, 16'h0A00, 4'b0000};
        vec[5]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd2, 5'd1, 3'd4, 16'h0A00, 4'b0000};
        vec[6]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd3, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[7]  = '{1'b1, 3'd5, 12'd9, 3'b111, 1'b1, 3'd0, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[8]  = '{1'b1, 3'd0, 12'd0, 3'b000, 1'b1, 3'd1, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[9]  = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd2, 5'd1, 3'd4, 16'h0000, 4'b0000};
        vec[10] = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd3, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[11] = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd0, 5'd0, 3'd0, 16'h0000, 4'b0000};
        vec[12] = '{1'b0, 3'd0, 12'd0, 3'b000, 1'b0, 3'd1, 5'd0, 3'd0, 16'h0000, 4'b0001};

        idle();
`ifdef WAVE_SCHED_HARD_SYNC_EN
        drv_mask = '0;
`endif
        rst_n = 1'b0;
        #1;
        check("reset_slot",   32'(slot),     32'd0);
        check("reset_sample", 32'(sample),   32'd0);
        check("reset_addr",   32'(lut_addr), 32'd0);
        check("reset_valid",  32'(valid),    32'd0);
        do_reset();

        // Directed table: V2 sawtooth capture and disable, ignored out-of-range voice, V0 enable.
        for (int i = 0; i < 13; i++) begin
            drv_we = vec[i].we; drv_voice = vec[i].voice; drv_period = vec[i].period;
            drv_type = vec[i].typ; drv_en = vec[i].en;
            cycle();
            check($sformatf("vec%0d_slot", i),   32'(slot),     32'(vec[i].exp_slot));
            check($sformatf("vec%0d_addr", i),   32'(lut_addr), 32'(vec[i].exp_addr));
            check($sformatf("vec%0d_type", i),   32'(wave_type), 32'(vec[i].exp_type));
            check($sformatf("vec%0d_sample", i), 32'(sample),   32'(vec[i].exp_sample));
            check($sformatf("vec%0d_valid", i),  32'(valid),    32'(vec[i].exp_valid));
        end

        // V0 period 0: phase walks through the full 0..31 range and wraps; square level follows phase[4].
        idle();
        exp_ph = 1;
        cap_ph = -1;
        for (int i = 0; i < 140; i++) begin
            cycle();
            if (slot == 0) begin
                check("v0_phase", 32'(lut_addr), 32'(exp_ph));
                cap_ph = exp_ph;
                exp_ph = (exp_ph + 1) % 32;
            end else if (slot == 1 && cap_ph >= 0) begin
                check("v0_square", 32'(sample[3:0]), (cap_ph >= 16) ? 32'hF : 32'h0);
                check("v0_valid",  32'(valid[0]),    32'd1);
            end
        end

        // V1 period 2, then a period-5 write on its visit: the step is dropped and the divider reloads.
        write_cfg(1, 2, 0, 1'b1);
        cycle();
        idle();
        repeat (40) cycle();
        while (slot != 1) cycle();
        pre_ph = int'(lut_addr);
        write_cfg(1, 5, 0, 1'b1);
        cycle();
        idle();
        visits = 0;
        while (visits < 7) begin
            cycle();
            if (slot == 1) begin
                visits++;
                check("v1_hold", 32'(lut_addr), (visits < 7) ? 32'(pre_ph) : 32'((pre_ph + 1) % 32));
            end
        end

        // Asynchronous reset mid-run, then the slot restarts from 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_slot",   32'(slot),     32'd0);
        check("midrst_sample", 32'(sample),   32'd0);
        check("midrst_addr",   32'(lut_addr), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("release_slot", 32'(slot), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("run_slot", 32'(slot), 32'(i % 4));
        end

`ifdef WAVE_SCHED_HARD_SYNC_EN
        // Hard sync: V1 (period 3) snaps to phase 0 whenever V0 wraps 31 -> 0.
        do_reset();
        drv_mask = 4'b0010;
        write_cfg(0, 0, 0, 1'b1);
        cycle();
        write_cfg(1, 3, 3'b101, 1'b1);
        cycle();
        idle();
        for (int i = 0; i < 300; i++) begin
            bit wrapping;
            wrapping = (slot == 0) && (lut_addr == 5'd31);
            cycle();
            if (wrapping) check("sync_v1_phase", 32'(lut_addr), 32'd0);
        end
`endif

        // Random configuration traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drv_we     = ($urandom_range(0, 5) == 0);
            drv_voice  = VW'($urandom_range(0, 7));
            drv_period = DW'($urandom_range(0, 3));
            drv_type   = 3'($urandom_range(0, 7));
            drv_en     = ($urandom_range(0, 3) != 0);
`ifdef WAVE_SCHED_HARD_SYNC_EN
            drv_mask   = N'($urandom_range(0, 15));
`endif
            cycle();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
